ahb_slave_mem: RTL and testbench

AHB-Lite memory slave that acts as the responder for the single-master AHB write/read path. It decodes address-phase signals from the bus and stores data in an internal word-organised register array. It supports byte, halfword and word transfers with little-endian lane selection. It inserts a fixed number of wait states and optionally issues two-cycle ERROR responses.

---
 rtl/ahb_slave_mem.sv | 163 ++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: word array with byte/half/word lanes and fixed wait states.
// Define AHB_SLAVE_ERR_EN for decode/alignment checks with a two-cycle ERROR response.
module ahb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef AHB_SLAVE_ERR_EN
  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;
`else
  typedef enum logic [1:0] {StIdle, StWait} state_e;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              act_q, act_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       mem_q [DEPTH];

  logic              accept;
  logic              can_accept;
  logic              commit;
  logic [IdxW-1:0]   addr_idx;
  logic [MemAw-1:0]  widx;
  logic [3:0]        lane_mask;
  logic              unused_ok;

  assign accept    = HSEL & HREADY & HTRANS[1];
  assign addr_idx  = HADDR[ADDR_WIDTH-1:2];
  assign unused_ok = ^{HADDR[31:ADDR_WIDTH], HTRANS[0]};
  // Out-of-range indices only reach here when error checking is off: wrap them.
  assign widx      = MemAw'(32'(idx_q) % DEPTH);

`ifdef AHB_SLAVE_ERR_EN
  logic addr_err;
  assign addr_err = (32'(addr_idx) >= DEPTH)
                  | ((HSIZE == 3'd1) & HADDR[0])
                  | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                  | (HSIZE > 3'd2);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    act_d      = act_q;
    write_d    = write_q;
    size_d     = size_q;
    off_d      = off_q;
    idx_d      = idx_q;
    commit     = 1'b0;
    can_accept = 1'b0;
    case (state_q)
      StIdle: begin
        can_accept = 1'b1;
        commit     = act_q & write_q;
        act_d      = 1'b0;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StIdle;
      end
`ifdef AHB_SLAVE_ERR_EN
      StErr1: state_d = StErr2;
      StErr2: begin
        can_accept = 1'b1;
        state_d    = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (can_accept && accept) begin
      idx_d   = addr_idx;
      off_d   = HADDR[1:0];
      write_d = HWRITE;
      size_d  = HSIZE;
`ifdef AHB_SLAVE_ERR_EN
      if (addr_err) begin
        act_d   = 1'b0;
        state_d = StErr1;
      end else
`endif
      begin
        act_d   = 1'b1;
        cnt_d   = 4'(WAIT_STATES);
        state_d = (WAIT_STATES != 0) ? StWait : StIdle;
      end
    end
  end

  always_comb begin
    lane_mask = 4'b1111;
    if (size_q == 3'd0) begin
      lane_mask = 4'b0001 << off_q;
    end else if (size_q == 3'd1) begin
      lane_mask = off_q[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      act_q   <= 1'b0;
      write_q <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      write_q <= write_d;
      size_q  <= size_d;
      off_q   <= off_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int w = 0; w < int'(DEPTH); w++) mem_q[w] <= '0;
    end else if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) mem_q[widx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = (state_q == StIdle)
`ifdef AHB_SLAVE_ERR_EN
                   | (state_q == StErr2)
`endif
                   ;
`ifdef AHB_SLAVE_ERR_EN
  assign HRESP = (state_q == StErr1) | (state_q == StErr2);
`else
  assign HRESP = 1'b0;
`endif
  // Read data is a live view of the array, so a write committed at the accept edge is seen.
  assign HRDATA = (act_q && !write_q) ? mem_q[widx] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: a zero-wait and a two-wait slave share one AHB-Lite bus,
// checked against an array model of the memory and the response timing rules.
module tb_ahb_slave_mem;

  localparam int unsigned Aw = 9;
  localparam int unsigned Dp = 64;

  logic        hclk, hresetn;
  logic        hsel_bus, tgt;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        ho0, ho1, hr0, hr1;
  logic [31:0] rd0, rd1;
  logic        hready_bus, hresp_bus;
  logic [31:0] hrdata_bus;

  assign hready_bus = ho0 & ho1;
  assign hresp_bus  = hr0 | hr1;
  assign hrdata_bus = rd0 | rd1;

  ahb_slave_mem #(.ADDR_WIDTH(Aw), .DEPTH(Dp), .WAIT_STATES(0)) u_dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_bus & ~tgt), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
    .HREADYOUT(ho0), .HRESP(hr0), .HRDATA(rd0)
  );

  ahb_slave_mem #(.ADDR_WIDTH(Aw), .DEPTH(Dp), .WAIT_STATES(2)) u_dut1 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel_bus & tgt), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
    .HREADYOUT(ho1), .HRESP(hr1), .HRDATA(rd1)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  typedef struct {
    bit          tgt;
    bit          idle;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          has_exp;
    logic [31:0] exp;
  } xfer_t;

  logic [31:0] mdl [2][Dp];
  int n_checks = 0;
  int n_err    = 0;

  function automatic xfer_t mk(input bit t, input bit w, input logic [2:0] s,
                               input logic [31:0] a, input logic [31:0] d,
                               input bit he, input logic [31:0] e);
    xfer_t x;
    x.tgt = t; x.idle = 1'b0; x.write = w; x.size = s; x.addr = a; x.wdata = d;
    x.has_exp = he; x.exp = e;
    return x;
  endfunction

  function automatic int midx(input logic [31:0] a);
    return (int'(a) & ((1 << Aw) - 1)) / 4 % Dp;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
`ifdef AHB_SLAVE_ERR_EN
    int word = (int'(a) & ((1 << Aw) - 1)) / 4;
    return (word >= Dp) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) || (s > 3'd2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] a, input logic [2:0] s);
    logic [31:0] r = old;
    int nbytes = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    int first  = (s == 3'd0) ? int'(a[1:0]) : (s == 3'd1) ? int'(a[1]) * 2 : 0;
    for (int b = first; b < first + nbytes; b++) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int t = 0; t < 2; t++) for (int w = 0; w < int'(Dp); w++) mdl[t][w] = 32'h0;
  endtask

  task automatic present_idle();
    hsel_bus = 1'b0; tgt = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h0;
  endtask

  task automatic present(input xfer_t x);
    tgt = x.tgt; haddr = x.addr; hwrite = x.write; hsize = x.size;
    if (x.idle) begin
      hsel_bus = 1'($urandom_range(1));
      htrans   = hsel_bus ? 2'($urandom_range(1)) : 2'b10;
    end else begin
      hsel_bus = 1'b1;
      htrans   = 2'($urandom_range(2, 3));
    end
  endtask

  // Drives a pipelined sequence; outputs observed and inputs changed on the falling edge.
  task automatic run(input xfer_t q[$]);
    int n = q.size();
    int i = 0;
    int dp = -1;
    int low = 0;
    int guard = 0;
    int exp_low;
    bit err;
    xfer_t t;
    while ((i < n || dp >= 0) && guard < 2000) begin
      @(negedge hclk);
      guard++;
      if (dp >= 0) begin
        t = q[dp];
        err = is_err(t.addr, t.size);
        exp_low = err ? 1 : (t.tgt ? 2 : 0);
        n_checks++;
        if (hresp_bus !== err) begin
          n_err++;
          $display("FAIL hresp addr=%h got %b want %b", t.addr, hresp_bus, err);
        end
        if (!hready_bus) begin
          low++;
          hwdata = $urandom;
          if (low > 20) begin
            n_err++;
            $display("FAIL ready_timeout addr=%h got low=%0d want %0d", t.addr, low, exp_low);
            i = n;
            dp = -1;
          end
        end else begin
          n_checks++;
          if (low != exp_low) begin
            n_err++;
            $display("FAIL wait_cycles addr=%h got %0d want %0d", t.addr, low, exp_low);
          end
          n_checks++;
          if (t.write || err) begin
            if (hrdata_bus !== 32'h0) begin
              n_err++;
              $display("FAIL hrdata_idle addr=%h got %h want 0", t.addr, hrdata_bus);
            end
          end else if (hrdata_bus !== mdl[t.tgt][midx(t.addr)]) begin
            n_err++;
            $display("FAIL read_model t=%0d addr=%h got %h want %h", t.tgt, t.addr, hrdata_bus,
                     mdl[t.tgt][midx(t.addr)]);
          end
          if (t.has_exp) begin
            n_checks++;
            if (hrdata_bus !== t.exp) begin
              n_err++;
              $display("FAIL read_const addr=%h got %h want %h", t.addr, hrdata_bus, t.exp);
            end
          end
          hwdata = t.wdata;
          if (t.write && !err) mdl[t.tgt][midx(t.addr)] =
              merge(mdl[t.tgt][midx(t.addr)], t.wdata, t.addr, t.size);
          dp = -1;
        end
      end
      if (hready_bus) begin
        if (i < n) begin
          present(q[i]);
          dp = q[i].idle ? -1 : i;
          low = 0;
          i++;
        end else begin
          present_idle();
        end
      end
    end
    if (i < n || dp >= 0) begin
      n_err++;
      $display("FAIL seq_timeout got pending=%0d want 0", n - i);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (hready_bus !== 1'b1 || hresp_bus !== 1'b0 || hrdata_bus !== 32'h0) begin
      n_err++;
      $display("FAIL %s got ready=%b resp=%b rdata=%h want 1 0 0", tag, hready_bus, hresp_bus,
               hrdata_bus);
    end
  endtask

  task automatic test_reset();
    xfer_t q[$];
    logic [31:0] a [6];
    hresetn = 1'b0;
    hwdata  = 32'h0;
    present_idle();
    clear_model();
    repeat (2) @(negedge hclk);
    check_reset_outputs("reset_values");
    hresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      a[k] = 32'($urandom_range(0, 63)) << 2;
      q.push_back(mk(k[0], 1'b1, 3'd2, a[k], $urandom | 32'h1, 1'b0, 32'h0));
    end
    run(q);
    // Start a read on the wait-state slave, then reset while it is stalled.
    @(negedge hclk);
    present(mk(1'b1, 1'b0, 3'd2, a[1], 32'h0, 1'b0, 32'h0));
    @(negedge hclk);
    n_checks++;
    if (hready_bus !== 1'b0) begin
      n_err++;
      $display("FAIL stall_before_reset got %b want 0", hready_bus);
    end
    #2 hresetn = 1'b0;
    #1 check_reset_outputs("reset_async");
    present_idle();
    @(negedge hclk);
    hresetn = 1'b1;
    clear_model();
    q.delete();
    for (int k = 0; k < 6; k++) q.push_back(mk(k[0], 1'b0, 3'd2, a[k], 32'h0, 1'b1, 32'h0));
    run(q);
  endtask

  task automatic test_lanes(input bit t);
    xfer_t q[$];
    q.push_back(mk(t, 1'b1, 3'd2, 32'h04, 32'hDEADBEEF, 1'b0, 32'h0));
    q.push_back(mk(t, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1, 32'hDEADBEEF));
    q.push_back(mk(t, 1'b1, 3'd0, 32'h05, 32'h5500AB77, 1'b0, 32'h0));
    q.push_back(mk(t, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1, 32'hDEADABEF));
    q.push_back(mk(t, 1'b1, 3'd1, 32'h06, 32'h1234CCDD, 1'b0, 32'h0));
    q.push_back(mk(t, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1, 32'h1234ABEF));
    run(q);
  endtask

  task automatic test_zero_wait();
    test_lanes(1'b0);
  endtask

  task automatic test_wait_states();
    test_lanes(1'b1);
  endtask

  task automatic test_errors();
    xfer_t q[$];
    xfer_t gap;
`ifdef AHB_SLAVE_ERR_EN
    logic [31:0] e1 = 32'hCAFEF00D, e2 = 32'hCAFEF00D, e3 = 32'h00000000;
`else
    logic [31:0] e1 = 32'h0BADBEEF, e2 = 32'h12121212, e3 = 32'h00009999;
`endif
    q.push_back(mk(1'b0, 1'b1, 3'd2, 32'h000, 32'hCAFEF00D, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 1'b1, 3'd2, 32'h100, 32'h0BADBEEF, 1'b0, 32'h0));
    gap = mk(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    gap.idle = 1'b1;
    q.push_back(gap);
    q.push_back(mk(1'b0, 1'b0, 3'd2, 32'h000, 32'h0, 1'b1, e1));
    q.push_back(mk(1'b0, 1'b1, 3'd2, 32'h002, 32'h12121212, 1'b0, 32'h0));
    q.push_back(mk(1'b0, 1'b0, 3'd2, 32'h000, 32'h0, 1'b1, e2));
    q.push_back(mk(1'b1, 1'b1, 3'd2, 32'h020, 32'h0, 1'b0, 32'h0));
    q.push_back(mk(1'b1, 1'b1, 3'd1, 32'h121, 32'h77779999, 1'b0, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 3'd2, 32'h020, 32'h0, 1'b1, e3));
    run(q);
  endtask

  task automatic test_back_to_back();
    xfer_t q[$];
    xfer_t x;
    for (int k = 0; k < 80; k++) begin
      x = mk(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(0, 2)),
             $urandom, $urandom, 1'b0, 32'h0);
      if ($urandom_range(7) == 0) x.size = 3'($urandom_range(3, 7));
      if ($urandom_range(3) != 0) x.addr[8] = 1'b0;
      if ($urandom_range(3) != 0) x.addr[1:0] = (x.size == 3'd1) ? {x.addr[1], 1'b0} :
                                                 (x.size == 3'd0) ? x.addr[1:0] : 2'b00;
      x.idle = ($urandom_range(5) == 0);
      q.push_back(x);
    end
    run(q);
  endtask

  task automatic test_reset_mid_wait();
    xfer_t q[$];
    @(negedge hclk);
    present(mk(1'b1, 1'b1, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0));
    hwdata = 32'h55AA55AA;
    repeat (2) @(negedge hclk);
    hresetn = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    present_idle();
    @(negedge hclk);
    hresetn = 1'b1;
    clear_model();
    q.push_back(mk(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'h0));
    q.push_back(mk(1'b0, 1'b0, 3'd2, 32'h04, 32'h0, 1'b1, 32'h0));
    run(q);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
